regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//   Parametrised 2-read/1-write register file built from enabled storage registers.
//   Optional hardwired-zero entry 0 and optional write-to-read bypass.
//   Per-entry busy scoreboard flags registers with a pending writer.
//   Sits in the CPU core between decode (reads, marks) and writeback (writes).
// PARAMETERS
//   WIDTH     32  data bits per register
//   ADDR_W    5   address bits; DEPTH = 2**ADDR_W entries
//   ZERO_REG  1   1: entry 0 reads 0, ignores writes, never busy
//   BYPASS    0   1: same-cycle write data forwarded to matching read port
//   RESET_VAL 0   value loaded into every entry on reset (WIDTH bits)
// PORTS
//   clk       in   1       clock; all state updates on rising edge
//   reset     in   1       synchronous, active-high reset
//   raddr1    in   ADDR_W  read port 1 address
//   raddr2    in   ADDR_W  read port 2 address
//   rdata1    out  WIDTH   read port 1 data (combinational)
//   rdata2    out  WIDTH   read port 2 data (combinational)
//   busy1     out  1       entry raddr1 has a pending writer
//   busy2     out  1       entry raddr2 has a pending writer
//   wrenable  in   1       write strobe
//   waddr     in   ADDR_W  write address
//   wdata     in   WIDTH   write data
//   mark_en   in   1       set busy bit of mark_addr
//   mark_addr in   ADDR_W  entry gaining a pending writer
// BEHAVIOUR
//   One clock; reset is synchronous and active-high.
//   Reset (edge with reset=1): every entry <= RESET_VAL (entry 0 stays 0 if ZERO_REG); all busy <= 0.
//   Reset dominates any write or mark in the same cycle.
//   Reset asserted mid-sequence discards pending marks; no state survives the reset edge.
//   Write: wrenable=1 at edge -> entry[waddr] <= wdata and busy[waddr] <= 0.
//   Writes are visible on rdata after that edge (1-cycle write latency).
//   Read: rdataN = entry[raddrN], combinational, zero latency; no read side effects.
//   BYPASS=1: wrenable=1 and waddr==raddrN (and not zero entry) -> rdataN=wdata, busyN=0 same cycle.
//   BYPASS=0: rdataN shows old value until the edge.
//   ZERO_REG=1: rdataN=0 and busyN=0 whenever raddrN==0; write and mark of entry 0 ignored.
//   Mark: mark_en=1 at edge -> busy[mark_addr] <= 1.
//   Mark and write to the same entry in one cycle: data written, busy ends 1 (new producer wins).
//   Mark and write to different entries: both take effect independently.
//   Both read ports may address the same entry; both return identical data.
//   Address space fully decoded; DEPTH == 2**ADDR_W, no out-of-range case.
//   busyN = busy[raddrN] except the bypass/zero overrides above.
// STRUCTURE
//   Shared package regfile_pkg: default WIDTH/ADDR_W localparams, ZERO_ADDR constant.
//   Sub-module register_param (WIDTH, RESET_VAL): d, q, wrenable, clk, reset.
//   Generate DEPTH instances of register_param; entry 0 replaced by constant 0 when ZERO_REG.
//   Write decoder one-hot on waddr gated by wrenable.
//   Read muxes are DEPTH:1 per port; busy vector is a DEPTH-bit register beside the array.
// TESTING
//   Reset: reset=1 one edge, then read all entries -> rdata=RESET_VAL (entry 0 = 0), busy1=busy2=0.
//   Write/read: write 32'hDEADBEEF to 5, 32'h12345678 to 31 -> raddr1=5, raddr2=31 return them next cycle.
//   Zero entry: write 32'hFFFFFFFF to 0, mark 0 -> rdata1(raddr1=0)=0, busy1=0.
//   Bypass: BYPASS=1, write 32'hA5A5A5A5 to 7 with raddr1=7 -> rdata1=A5A5A5A5 before edge.
//   Bypass off: BYPASS=0, same stimulus -> rdata1 holds old value until after the edge.
//   Scoreboard: mark 9 -> busy1=1 next cycle; write 9 -> busy1=0; mark+write 9 together -> busy1=1, data updated.
//   Reset priority: reset=1 with wrenable=1, waddr=3, mark 3 -> entry 3=RESET_VAL, busy=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the parametrised register file.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned ZERO_ADDR  = 0;

endpackage

// File: rtl/regfile_param_register.sv
// Single enabled storage register with synchronous active-high reset.
module register_param
  import regfile_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrenable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (wrenable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// 2-read/1-write register file with busy scoreboard, optional zero entry
// and optional write-to-read forwarding.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      ADDR_W    = DEF_ADDR_W,
  parameter bit               ZERO_REG  = 1'b1,
  parameter bit               BYPASS    = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2,
  output logic              busy1,
  output logic              busy2,
  input  logic              wrenable,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] entry [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic zero1_c;
  logic zero2_c;
  logic fwd1_c;
  logic fwd2_c;

  // Storage array; each entry's enable is its slice of the one-hot write decode
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    if (ZERO_REG && (i == ZERO_ADDR)) begin : g_zero
      assign entry[i] = '0;
    end else begin : g_reg
      logic we_c;
      assign we_c = wrenable && (waddr == ADDR_W'(i));
      register_param #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
      ) u_reg (
        .clk     (clk),
        .reset   (reset),
        .wrenable(we_c),
        .d       (wdata),
        .q       (entry[i])
      );
    end
  end

  // Mark is applied after the write clear so a new producer wins
  always_comb begin
    busy_d = busy_q;
    if (wrenable) begin
      busy_d[waddr] = 1'b0;
    end
    if (mark_en) begin
      busy_d[mark_addr] = 1'b1;
    end
    if (ZERO_REG) begin
      busy_d[ADDR_W'(ZERO_ADDR)] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Read ports: zero entry overrides forwarding, forwarding overrides the array
  always_comb begin
    zero1_c = ZERO_REG && (raddr1 == ADDR_W'(ZERO_ADDR));
    zero2_c = ZERO_REG && (raddr2 == ADDR_W'(ZERO_ADDR));
    fwd1_c  = BYPASS && wrenable && (waddr == raddr1);
    fwd2_c  = BYPASS && wrenable && (waddr == raddr2);

    rdata1 = entry[raddr1];
    busy1  = busy_q[raddr1];
    if (zero1_c) begin
      rdata1 = '0;
      busy1  = 1'b0;
    end else if (fwd1_c) begin
      rdata1 = wdata;
      busy1  = 1'b0;
    end

    rdata2 = entry[raddr2];
    busy2  = busy_q[raddr2];
    if (zero2_c) begin
      rdata2 = '0;
      busy2  = 1'b0;
    end else if (fwd2_c) begin
      rdata2 = wdata;
      busy2  = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed + random bench for regfile_param, with and without forwarding.
module tb_regfile_param;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned D  = 32;
  localparam logic [W-1:0] RV = 32'h0BAD_F00D;

  logic          clk = 1'b0;
  logic          reset;
  logic          wrenable;
  logic          mark_en;
  logic [AW-1:0] raddr1, raddr2, waddr, mark_addr;
  logic [W-1:0]  wdata;

  logic [W-1:0] rd1_n, rd2_n, rd1_b, rd2_b;
  logic         bz1_n, bz2_n, bz1_b, bz2_b;

  always #5 clk = ~clk;

  regfile_param #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b0), .RESET_VAL(RV)) dut_n (
    .clk(clk), .reset(reset), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rd1_n), .rdata2(rd2_n), .busy1(bz1_n), .busy2(bz2_n),
    .wrenable(wrenable), .waddr(waddr), .wdata(wdata),
    .mark_en(mark_en), .mark_addr(mark_addr)
  );

  regfile_param #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1), .RESET_VAL(RV)) dut_b (
    .clk(clk), .reset(reset), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rd1_b), .rdata2(rd2_b), .busy1(bz1_b), .busy2(bz2_b),
    .wrenable(wrenable), .waddr(waddr), .wdata(wdata),
    .mark_en(mark_en), .mark_addr(mark_addr)
  );

  typedef struct {
    string        tag;
    logic [W-1:0] val;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] mem_m [D];
  logic [D-1:0] busy_m;

  function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (a == '0) return '0;
    if (byp && wrenable && (waddr == a)) return wdata;
    return mem_m[a];
  endfunction

  function automatic logic [W-1:0] exp_busy(input logic [AW-1:0] a, input bit byp);
    if (a == '0) return '0;
    if (byp && wrenable && (waddr == a)) return '0;
    return W'(busy_m[a]);
  endfunction

  task automatic push(input string tag, input logic [W-1:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic cmp(input logic [W-1:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow observed %h required queued value", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                       input logic [W-1:0] wd, input logic me, input logic [AW-1:0] ma,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    reset = r; wrenable = we; waddr = wa; wdata = wd;
    mark_en = me; mark_addr = ma; raddr1 = a1; raddr2 = a2;
  endtask

  // Queue expected port values from the model, then compare after settling
  task automatic sample(input string tag);
    push({tag, ".n.rd1"}, exp_rd(raddr1, 1'b0));
    push({tag, ".n.rd2"}, exp_rd(raddr2, 1'b0));
    push({tag, ".n.bz1"}, exp_busy(raddr1, 1'b0));
    push({tag, ".n.bz2"}, exp_busy(raddr2, 1'b0));
    push({tag, ".b.rd1"}, exp_rd(raddr1, 1'b1));
    push({tag, ".b.rd2"}, exp_rd(raddr2, 1'b1));
    push({tag, ".b.bz1"}, exp_busy(raddr1, 1'b1));
    push({tag, ".b.bz2"}, exp_busy(raddr2, 1'b1));
    #1;
    cmp(rd1_n); cmp(rd2_n); cmp(W'(bz1_n)); cmp(W'(bz2_n));
    cmp(rd1_b); cmp(rd2_b); cmp(W'(bz1_b)); cmp(W'(bz2_b));
  endtask

  // Advance the model with the current inputs, then take the clock edge
  task automatic cycle();
    if (reset) begin
      for (int i = 0; i < D; i++) mem_m[i] = (i == 0) ? '0 : RV;
      busy_m = '0;
    end else begin
      if (wrenable && (waddr != '0)) begin
        mem_m[waddr]  = wdata;
        busy_m[waddr] = 1'b0;
      end
      if (mark_en && (mark_addr != '0)) busy_m[mark_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
    @(negedge clk);
    cycle();

    for (int a = 0; a < D; a++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, AW'(a), AW'(D - 1 - a));
      sample("reset_sweep");
      cycle();
    end

    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 5'd5, 5'd31);
    sample("wr5_pre");
    cycle();
    drive(1'b0, 1'b1, 5'd31, 32'h12345678, 1'b0, '0, 5'd5, 5'd31);
    sample("wr31_pre");
    cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd31);
    sample("wr_post");

    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    sample("zero_pre");
    cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd5);
    sample("zero_post");

    drive(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, '0, 5'd7, 5'd7);
    sample("byp7_pre");
    cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd6);
    sample("byp7_post");

    drive(1'b0, 1'b1, 5'd12, 32'h0000C0C0, 1'b1, 5'd9, 5'd9, 5'd12);
    sample("mark9_pre");
    cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd12);
    sample("mark9_post");
    drive(1'b0, 1'b1, 5'd9, 32'h00000042, 1'b0, '0, 5'd9, 5'd12);
    sample("wr9_pre");
    cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd12);
    sample("wr9_post");
    drive(1'b0, 1'b1, 5'd9, 32'h00000099, 1'b1, 5'd9, 5'd9, 5'd9);
    sample("mkwr9_pre");
    cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd9);
    sample("mkwr9_post");

    drive(1'b0, 1'b1, 5'd3, 32'h33333333, 1'b0, '0, 5'd3, 5'd9);
    cycle();
    drive(1'b1, 1'b1, 5'd3, 32'h77777777, 1'b1, 5'd3, 5'd3, 5'd9);
    cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd9);
    sample("rst_prio");

    for (int n = 0; n < 60; n++) begin
      drive(($urandom_range(0, 15) == 0), 1'($urandom), AW'($urandom), $urandom,
            1'($urandom), AW'($urandom), AW'($urandom), AW'($urandom));
      if ($urandom_range(0, 3) == 0) raddr1 = waddr;
      if ($urandom_range(0, 3) == 0) raddr2 = mark_addr;
      sample("random");
      cycle();
    end

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL sb_leftover observed %0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
